mc_control_unit: RTL and testbench
==================================

# mc_control_unit

Multicycle MIPS control unit. A Moore state machine plus ALU decoder that sequences each instruction through fetch, decode, execute, memory and writeback, driving the datapath mux selects, write enables and the 3-bit ALU function code. Sits directly upstream of the ALU: `alucontrol` drives the ALU function input `F`, and the ALU's `Zero` output returns as `zero` to resolve branches.

## Interface
Parameters: none; opcode and funct encodings are fixed by the MIPS ISA.

- `clk` in 1: single system clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `op` in 6: instruction opcode, instr[31:26], taken from the instruction register.
- `funct` in 6: instruction funct field, instr[5:0].
- `zero` in 1: the ALU's `Zero` flag.
- `iord` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `memwrite` out 1: memory write enable.
- `irwrite` out 1: instruction register load enable.
- `regdst` out 1: write register select; 0 = rt, 1 = rd.
- `memtoreg` out 1: writeback data select; 0 = ALUOut, 1 = memory data.
- `regwrite` out 1: register file write enable.
- `alusrca` out 1: ALU A select; 0 = PC, 1 = register A.
- `alusrcb` out 2: ALU B select; 00 = register B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
- `pcsrc` out 2: next-PC select; 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `pcen` out 1: PC load enable.
- `alucontrol` out 3: ALU function code.
- `state` out 4: current state, for debug.

## Operation
State encoding:
- 0 FETCH
- 1 DECODE
- 2 MEMADR
- 3 MEMRD
- 4 MEMWB
- 5 MEMWR
- 6 RTYPEEX
- 7 RTYPEWB
- 8 BEQEX
- 9 ADDIEX
- 10 ADDIWB
- 11 JEX
- Codes 12–15 are illegal and return to FETCH on the next edge.

Transitions:
- FETCH → DECODE.
- DECODE, by `op`:
  - 100011 (lw) or 101011 (sw) → MEMADR.
  - 000000 (R-type) → RTYPEEX.
  - 000100 (beq) → BEQEX.
  - 001000 (addi) → ADDIEX.
  - 000010 (j) → JEX.
  - Any other `op` → FETCH; the instruction is dropped with no write.
- MEMADR: lw → MEMRD; sw → MEMWR.
- MEMRD → MEMWB.
- RTYPEEX → RTYPEWB.
- ADDIEX → ADDIWB.
- MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB and JEX → FETCH.

Moore outputs per state; any signal not listed is 0:
- FETCH: `alusrcb`=01, aluop=00, `irwrite`=1, pcwrite=1.
- DECODE: `alusrcb`=11, aluop=00.
- MEMADR: `alusrca`=1, `alusrcb`=10, aluop=00.
- MEMRD: `iord`=1.
- MEMWB: `memtoreg`=1, `regwrite`=1.
- MEMWR: `iord`=1, `memwrite`=1.
- RTYPEEX: `alusrca`=1, aluop=10.
- RTYPEWB: `regdst`=1, `regwrite`=1.
- BEQEX: `alusrca`=1, aluop=01, `pcsrc`=01, branch=1.
- ADDIEX: `alusrca`=1, `alusrcb`=10, aluop=00.
- ADDIWB: `regwrite`=1.
- JEX: `pcsrc`=10, pcwrite=1.

Derived signals:
- `pcen` = pcwrite | (branch & `zero`). It is combinational, because `zero` arrives from the ALU in the same cycle.
- ALU decode is combinational:
  - aluop 00 → 010 (add).
  - aluop 01 → 110 (sub).
  - aluop 10, by `funct`:
    - 100000 → 010 (add).
    - 100010 → 110 (sub).
    - 100100 → 000 (and).
    - 100101 → 001 (or).
    - 101010 → 111 (slt).
    - Any other `funct` → 010. The instruction still writes back in RTYPEWB.

## Timing
Reset:
- `reset_n` low forces `state` to FETCH immediately, without waiting for a clock edge.
- While `reset_n` is low, `irwrite`, `pcen`, `regwrite` and `memwrite` are forced to 0.
- All other outputs show FETCH values while `reset_n` is low: `alusrcb`=01, `alucontrol`=010, everything else 0.
- The first FETCH with active enables is the first cycle after `reset_n` rises.
- Reset asserted mid-instruction abandons the instruction and suppresses any pending write.

Cycles per instruction (FETCH counted):
- lw: 5.
- sw: 4.
- R-type: 4.
- addi: 4.
- beq: 3.
- j: 3.
- Unknown opcode: 2.

Output timing:
- Each write enable is high for exactly one cycle per instruction.
- State-derived outputs change only after a clock edge.
- Only `pcen` (through `zero`) and `alucontrol` (through `funct`) may change within a cycle.
- `op` and `funct` must be stable from DECODE through the end of the instruction.

## Test plan
- **Reset.** Hold `reset_n`=0 over 3 edges, then release.
  - While low: `state`=0, `irwrite`=0, `pcen`=0.
  - Cycle after release: `irwrite`=1, `pcen`=1, `alucontrol`=010.
- **lw.** Apply `op`=100011.
  - State sequence 0,1,2,3,4, then back to 0.
  - `iord`=1 in state 3.
  - `regwrite`=1 and `memtoreg`=1 only in state 4.
- **R-type.** Apply `op`=000000 with each `funct` in turn: 100000, 100010, 100100, 100101, 101010.
  - `alucontrol` in state 6 is 010, 110, 000, 001, 111 respectively.
  - `regdst`=1 in state 7.
- **beq.** Apply `op`=000100.
  - With `zero`=1 in state 8: `pcen`=1 and `pcsrc`=01.
  - With `zero`=0: `pcen`=0.
  - Either way the next state is 0.
- **j, sw and illegal opcode.**
  - j: sequence 0,1,11, with `pcsrc`=10 and `pcen`=1 in state 11.
  - sw: sequence 0,1,2,5, with `memwrite` high for exactly one cycle.
  - `op`=111111: sequence 0,1,0, with no write enable asserted.
- **Reset mid-write.** Assert `reset_n`=0 asynchronously while in state 7.
  - `regwrite` drops to 0 immediately.
  - `state` reads 0.

Source files
------------

// File: rtl/mc_control_unit.sv
// Multicycle MIPS control unit: Moore sequencer for fetch/decode/execute/memory/writeback
// plus the combinational ALU function decoder feeding the ALU's F input.
module mc_control_unit (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_t      state_r;
    state_t      next_state_s;
    logic        iord_s;
    logic        memwrite_s;
    logic        irwrite_s;
    logic        regdst_s;
    logic        memtoreg_s;
    logic        regwrite_s;
    logic        alusrca_s;
    logic [1:0]  alusrcb_s;
    logic [1:0]  pcsrc_s;
    logic        pcwrite_s;
    logic        branch_s;
    logic [1:0]  aluop_s;
    logic [2:0]  alucontrol_s;

    // State register; reset lands in FETCH without waiting for a clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state selection and Moore output decode for the current state.
    always_comb begin
        next_state_s = FETCH;
        iord_s       = 1'b0;
        memwrite_s   = 1'b0;
        irwrite_s    = 1'b0;
        regdst_s     = 1'b0;
        memtoreg_s   = 1'b0;
        regwrite_s   = 1'b0;
        alusrca_s    = 1'b0;
        alusrcb_s    = 2'b00;
        pcsrc_s      = 2'b00;
        pcwrite_s    = 1'b0;
        branch_s     = 1'b0;
        aluop_s      = 2'b00;
        case (state_r)
            FETCH: begin
                next_state_s = DECODE;
                alusrcb_s    = 2'b01;
                irwrite_s    = 1'b1;
                pcwrite_s    = 1'b1;
            end
            DECODE: begin
                alusrcb_s = 2'b11;
                case (op)
                    OP_LW, OP_SW: next_state_s = MEMADR;
                    OP_RTYPE:     next_state_s = RTYPEEX;
                    OP_BEQ:       next_state_s = BEQEX;
                    OP_ADDI:      next_state_s = ADDIEX;
                    OP_J:         next_state_s = JEX;
                    default:      next_state_s = FETCH;
                endcase
            end
            MEMADR: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
                if (op == OP_LW) begin
                    next_state_s = MEMRD;
                end else begin
                    next_state_s = MEMWR;
                end
            end
            MEMRD: begin
                next_state_s = MEMWB;
                iord_s       = 1'b1;
            end
            MEMWB: begin
                memtoreg_s = 1'b1;
                regwrite_s = 1'b1;
            end
            MEMWR: begin
                iord_s     = 1'b1;
                memwrite_s = 1'b1;
            end
            RTYPEEX: begin
                next_state_s = RTYPEWB;
                alusrca_s    = 1'b1;
                aluop_s      = 2'b10;
            end
            RTYPEWB: begin
                regdst_s   = 1'b1;
                regwrite_s = 1'b1;
            end
            BEQEX: begin
                alusrca_s = 1'b1;
                aluop_s   = 2'b01;
                pcsrc_s   = 2'b01;
                branch_s  = 1'b1;
            end
            ADDIEX: begin
                next_state_s = ADDIWB;
                alusrca_s    = 1'b1;
                alusrcb_s    = 2'b10;
            end
            ADDIWB: begin
                regwrite_s = 1'b1;
            end
            JEX: begin
                pcsrc_s   = 2'b10;
                pcwrite_s = 1'b1;
            end
            default: begin
                next_state_s = FETCH;
            end
        endcase
    end

    // ALU function decode; funct only matters while executing an R-type.
    always_comb begin
        alucontrol_s = 3'b010;
        case (aluop_s)
            2'b00: alucontrol_s = 3'b010;
            2'b01: alucontrol_s = 3'b110;
            2'b10: begin
                case (funct)
                    6'b100000: alucontrol_s = 3'b010;
                    6'b100010: alucontrol_s = 3'b110;
                    6'b100100: alucontrol_s = 3'b000;
                    6'b100101: alucontrol_s = 3'b001;
                    6'b101010: alucontrol_s = 3'b111;
                    default:   alucontrol_s = 3'b010;
                endcase
            end
            default: alucontrol_s = 3'b010;
        endcase
    end

    // Enables are gated by reset so an abandoned instruction can never write.
    assign irwrite    = irwrite_s  & reset_n;
    assign regwrite   = regwrite_s & reset_n;
    assign memwrite   = memwrite_s & reset_n;
    assign pcen       = reset_n & (pcwrite_s | (branch_s & zero));
    assign iord       = iord_s;
    assign regdst     = regdst_s;
    assign memtoreg   = memtoreg_s;
    assign alusrca    = alusrca_s;
    assign alusrcb    = alusrcb_s;
    assign pcsrc      = pcsrc_s;
    assign alucontrol = alucontrol_s;
    assign state      = state_r;

endmodule

// File: tb/tb_mc_control_unit.sv
// Randomized self-checking bench for mc_control_unit against an instruction-level
// model (instruction class + step within the instruction).
module tb_mc_control_unit;

    logic       clk;
    logic       reset_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    mc_control_unit dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
        .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
        .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .pcen(pcen),
        .alucontrol(alucontrol), .state(state)
    );

    localparam int C_LW = 0, C_SW = 1, C_RT = 2, C_BEQ = 3, C_ADDI = 4, C_J = 5, C_BAD = 6;

    int checks = 0;
    int failures = 0;
    logic chk_en = 1'b0;

    logic       exp_iord, exp_memwrite, exp_irwrite, exp_regdst, exp_memtoreg;
    logic       exp_regwrite, exp_alusrca, exp_pcen;
    logic [1:0] exp_alusrcb, exp_pcsrc;
    logic [2:0] exp_alu;
    logic [3:0] exp_state;

    logic [3:0] cap_state[8];
    logic       cap_irwrite[8], cap_pcen[8], cap_iord[8], cap_regdst[8], cap_memtoreg[8];
    logic [1:0] cap_pcsrc[8];
    logic [2:0] cap_alu[8];
    int n_rw, n_mw;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int class_of(input logic [5:0] o);
        case (o)
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b000000: return C_RT;
            6'b000100: return C_BEQ;
            6'b001000: return C_ADDI;
            6'b000010: return C_J;
            default:   return C_BAD;
        endcase
    endfunction

    function automatic int seq_len(input int cls);
        case (cls)
            C_LW:           return 5;
            C_SW, C_RT, C_ADDI: return 4;
            C_BEQ, C_J:     return 3;
            default:        return 2;
        endcase
    endfunction

    // State visited at a given step of an instruction of a given class.
    function automatic logic [3:0] seq_state(input int cls, input int step);
        if (step == 0) return 4'd0;
        if (step == 1) return 4'd1;
        case (cls)
            C_LW:    return (step == 2) ? 4'd2 : (step == 3) ? 4'd3 : 4'd4;
            C_SW:    return (step == 2) ? 4'd2 : 4'd5;
            C_RT:    return (step == 2) ? 4'd6 : 4'd7;
            C_BEQ:   return 4'd8;
            C_ADDI:  return (step == 2) ? 4'd9 : 4'd10;
            C_J:     return 4'd11;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [2:0] alu_of_funct(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected outputs from the instruction's role at this step.
    task automatic set_expect(input int cls, input int step, input logic z, input logic [5:0] fn);
        bit last;
        bit writes_reg;
        last         = (step == seq_len(cls) - 1);
        writes_reg   = (cls == C_LW) || (cls == C_RT) || (cls == C_ADDI);
        exp_state    = seq_state(cls, step);
        exp_irwrite  = (step == 0);
        exp_regwrite = last && writes_reg;
        exp_memwrite = last && (cls == C_SW);
        exp_iord     = (step == 3) && ((cls == C_LW) || (cls == C_SW));
        exp_memtoreg = (cls == C_LW) && (step == 4);
        exp_regdst   = (cls == C_RT) && (step == 3);
        exp_alusrca  = (step == 2) && (cls != C_J) && (cls != C_BAD);
        if (step == 0)      exp_alusrcb = 2'b01;
        else if (step == 1) exp_alusrcb = 2'b11;
        else if (step == 2 && (cls == C_LW || cls == C_SW || cls == C_ADDI)) exp_alusrcb = 2'b10;
        else                exp_alusrcb = 2'b00;
        if (step == 2 && cls == C_BEQ)    exp_pcsrc = 2'b01;
        else if (step == 2 && cls == C_J) exp_pcsrc = 2'b10;
        else                              exp_pcsrc = 2'b00;
        exp_pcen = (step == 0) || (step == 2 && cls == C_J) || (step == 2 && cls == C_BEQ && z);
        if (step == 2 && cls == C_RT)       exp_alu = alu_of_funct(fn);
        else if (step == 2 && cls == C_BEQ) exp_alu = 3'b110;
        else                                exp_alu = 3'b010;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("state",      state,      exp_state);
            check("irwrite",    irwrite,    exp_irwrite);
            check("regwrite",   regwrite,   exp_regwrite);
            check("memwrite",   memwrite,   exp_memwrite);
            check("iord",       iord,       exp_iord);
            check("memtoreg",   memtoreg,   exp_memtoreg);
            check("regdst",     regdst,     exp_regdst);
            check("alusrca",    alusrca,    exp_alusrca);
            check("alusrcb",    alusrcb,    exp_alusrcb);
            check("pcsrc",      pcsrc,      exp_pcsrc);
            check("pcen",       pcen,       exp_pcen);
            check("alucontrol", alucontrol, exp_alu);
        end
    end

    // Runs one instruction starting just after the edge entering FETCH.
    // zmode: 0/1 fixed zero, 2 random per cycle. abort_step >= 0 resets mid-cycle there.
    task automatic run_instr(input logic [5:0] iop, input logic [5:0] ifn,
                             input int zmode, input int abort_step);
        int cls;
        int n;
        cls = class_of(iop);
        n = seq_len(cls);
        op = iop;
        funct = ifn;
        n_rw = 0;
        n_mw = 0;
        for (int s = 0; s < n; s++) begin
            zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
            set_expect(cls, s, zero, ifn);
            if (s == abort_step) begin
                #2;
                check("pre_reset_regwrite", regwrite, 1'b1);
                chk_en = 1'b0;
                reset_n = 1'b0;
                #1;
                check("midreset_regwrite", regwrite, 1'b0);
                check("midreset_state", state, 4'd0);
                check("midreset_irwrite", irwrite, 1'b0);
                check("midreset_pcen", pcen, 1'b0);
                check("midreset_alusrcb", alusrcb, 2'b01);
                check("midreset_alucontrol", alucontrol, 3'b010);
                return;
            end
            @(negedge clk);
            cap_state[s]    = state;
            cap_irwrite[s]  = irwrite;
            cap_pcen[s]     = pcen;
            cap_iord[s]     = iord;
            cap_regdst[s]   = regdst;
            cap_memtoreg[s] = memtoreg;
            cap_pcsrc[s]    = pcsrc;
            cap_alu[s]      = alucontrol;
            n_rw += int'(regwrite);
            n_mw += int'(memwrite);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_random(input int count);
        logic [5:0] o;
        logic [5:0] f;
        logic [5:0] flist[5];
        flist = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        for (int i = 0; i < count; i++) begin
            case ($urandom_range(0, 6))
                0: o = 6'b100011;
                1: o = 6'b101011;
                2: o = 6'b000000;
                3: o = 6'b000100;
                4: o = 6'b001000;
                5: o = 6'b000010;
                default: o = 6'($urandom_range(0, 63));
            endcase
            if ($urandom_range(0, 1) == 1) f = flist[$urandom_range(0, 4)];
            else                           f = 6'($urandom_range(0, 63));
            run_instr(o, f, 2, -1);
        end
    endtask

    initial begin
        logic [5:0] rfn[5];
        logic [2:0] ralu[5];
        rfn  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        ralu = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
        reset_n = 1'b1;
        op = 6'b100011;
        funct = 6'b0;
        zero = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        check("reset_state_immediate", state, 4'd0);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("reset_state", state, 4'd0);
            check("reset_irwrite", irwrite, 1'b0);
            check("reset_pcen", pcen, 1'b0);
            check("reset_regwrite", regwrite, 1'b0);
            check("reset_memwrite", memwrite, 1'b0);
            check("reset_alucontrol", alucontrol, 3'b010);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        chk_en = 1'b1;

        run_instr(6'b100011, 6'b0, 2, -1);
        check("post_reset_irwrite", cap_irwrite[0], 1'b1);
        check("post_reset_pcen", cap_pcen[0], 1'b1);
        check("post_reset_alu", cap_alu[0], 3'b010);
        for (int s = 0; s < 5; s++) check("lw_seq", cap_state[s], 4'(s));
        check("lw_back_to_fetch", state, 4'd0);
        check("lw_iord_s3", cap_iord[3], 1'b1);
        check("lw_memtoreg_s4", cap_memtoreg[4], 1'b1);
        check("lw_memtoreg_s3", cap_memtoreg[3], 1'b0);
        check("lw_regwrite_count", 8'(n_rw), 8'd1);

        for (int i = 0; i < 5; i++) begin
            run_instr(6'b000000, rfn[i], 2, -1);
            check("rtype_state6", cap_state[2], 4'd6);
            check("rtype_alu", cap_alu[2], ralu[i]);
            check("rtype_state7", cap_state[3], 4'd7);
            check("rtype_regdst", cap_regdst[3], 1'b1);
        end

        run_instr(6'b000100, 6'b0, 1, -1);
        check("beq_state", cap_state[2], 4'd8);
        check("beq_taken_pcen", cap_pcen[2], 1'b1);
        check("beq_pcsrc", cap_pcsrc[2], 2'b01);
        check("beq_taken_next", state, 4'd0);
        run_instr(6'b000100, 6'b0, 0, -1);
        check("beq_not_taken_pcen", cap_pcen[2], 1'b0);
        check("beq_not_taken_next", state, 4'd0);

        run_instr(6'b000010, 6'b0, 2, -1);
        check("j_state", cap_state[2], 4'd11);
        check("j_pcsrc", cap_pcsrc[2], 2'b10);
        check("j_pcen", cap_pcen[2], 1'b1);

        run_instr(6'b101011, 6'b0, 2, -1);
        check("sw_state2", cap_state[2], 4'd2);
        check("sw_state5", cap_state[3], 4'd5);
        check("sw_memwrite_count", 8'(n_mw), 8'd1);

        run_instr(6'b111111, 6'b0, 2, -1);
        check("bad_decode", cap_state[1], 4'd1);
        check("bad_next", state, 4'd0);
        check("bad_writes", 8'(n_rw + n_mw), 8'd0);

        run_instr(6'b001000, 6'b0, 2, -1);
        check("addi_state9", cap_state[2], 4'd9);
        check("addi_state10", cap_state[3], 4'd10);
        check("addi_regwrite_count", 8'(n_rw), 8'd1);

        run_random(300);

        run_instr(6'b000000, 6'b100101, 2, 3);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("held_reset_state", state, 4'd0);
        check("held_reset_regwrite", regwrite, 1'b0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        chk_en = 1'b1;
        run_random(40);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
